// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port data memory between the fetch stage (read-only) and
// the memory stage (load/store). Every access runs through
//     IDLE -> ISSUE -> WAIT -> DONE -> IDLE
// and an out-of-range address short-circuits IDLE -> DONE, reporting a Y86
// ADR error without ever raising mem_req.
//
// Arbitration: the memory stage wins over fetch, except that once fetch has
// been passed over STARVE_MAX consecutive times while pending, fetch is
// forced to win the next grant.
//
// Optional feature (macro DMEM_ARB_TIMEOUT_EN):
//   When defined, an ack watchdog counts cycles spent in ISSUE/WAIT. After
//   TIMEOUT cycles with no mem_ack the access is abandoned: mem_req drops
//   and the owner receives valid+err (ADR) with rdata = 0. A late ack is
//   then ignored because the FSM has already left ISSUE/WAIT.
//   When undefined, WAIT holds until mem_ack or rst.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   f_req/f_addr           fetch read request (held until f_valid)
//   f_rdata/f_valid/f_err  fetch response, 1-cycle pulse
//   f_stall                f_req & ~f_valid
//   m_req/m_we/m_addr/
//   m_wdata                memory-stage request (held until m_valid)
//   m_rdata/m_valid/m_err  memory-stage response, 1-cycle pulse
//   m_stall                m_req & ~m_valid
//   mem_req/mem_we/
//   mem_addr/mem_wdata     memory-side request, held stable until mem_ack
//   mem_rdata/mem_ack      memory-side response
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_BYTES  = 1024,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_valid,
    output logic              f_err,
    output logic              f_stall,

    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_valid,
    output logic              m_err,
    output logic              m_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // Highest legal word address; compared at full ADDR_W so huge addresses
    // can never wrap back into range.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);
    localparam int                SC_W      = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(STARVE_MAX);

    // Requester indices: 0 = fetch, 1 = memory stage.
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_M = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_req;
    logic [SC_W-1:0]   r_starve_cnt;

    // Per-requester response registers, indexed by owner.
    logic [1:0]        r_valid;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata [2];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              w_idle;
    logic              w_busy;
    logic              w_f_forced;
    logic              w_grant_any;
    logic              w_grant_m;
    logic              w_grant_f;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_grant_adr;
    logic              w_ack_take;
    logic              w_tmo_hit;

    assign w_idle      = (r_state == S_IDLE);
    assign w_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // Fetch has been passed over STARVE_MAX times in a row: it wins now.
    assign w_f_forced  = f_req && (r_starve_cnt == SC_MAX);
    assign w_grant_any = w_idle && (f_req || m_req);
    assign w_grant_m   = w_grant_any && m_req && !w_f_forced;
    assign w_grant_f   = w_grant_any && !w_grant_m;

    assign w_grant_addr = w_grant_m ? m_addr : f_addr;

    // The range check is made on the address being latched at grant, so the
    // ADR response can be produced on the very next cycle.
    assign w_grant_adr  = (w_grant_addr > LAST_ADDR);

    // An ack is only meaningful while a memory request is outstanding.
    assign w_ack_take   = w_busy && mem_ack;

    // ------------------------------------------------------------------
    // Ack watchdog
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts cycles with mem_req outstanding; zero in ISSUE's cycle, so the
    // request is abandoned after exactly TIMEOUT cycles of mem_req high.
    always_ff @(posedge clk) begin
        if (rst || !w_busy) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A real ack in the final cycle takes precedence over the watchdog.
    assign w_tmo_hit = w_busy && !mem_ack && (r_tmo_cnt == TMO_LAST);
`else
    // Without the watchdog TIMEOUT has no effect; WAIT holds until ack/rst.
    assign w_tmo_hit = 1'b0 & (TIMEOUT > 0);
`endif

    // ------------------------------------------------------------------
    // Main FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_F;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_req    <= 1'b0;
            r_starve_cnt <= '0;
            r_valid      <= '0;
            r_err        <= '0;
            r_rdata[0]   <= '0;
            r_rdata[1]   <= '0;
        end else begin
            // Response pulses last a single cycle unless re-armed below.
            r_valid    <= '0;
            r_err      <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;

            // Starvation tracking: only consecutive M wins over a pending F
            // count; any cycle without f_req, or an F grant, resets it.
            if (!f_req || w_grant_f) begin
                r_starve_cnt <= '0;
            end else if (w_grant_m && (r_starve_cnt != SC_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner <= w_grant_m ? OWN_M : OWN_F;
                        r_we    <= w_grant_m && m_we;
                        r_addr  <= w_grant_addr;
                        r_wdata <= w_grant_m ? m_wdata : '0;
                        if (w_grant_adr) begin
                            // ADR: answer immediately, memory untouched.
                            r_state              <= S_DONE;
                            r_valid[w_grant_m]   <= 1'b1;
                            r_err[w_grant_m]     <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_mem_req <= 1'b1;
                        end
                    end
                end

                S_ISSUE, S_WAIT: begin
                    if (w_ack_take) begin
                        r_mem_req        <= 1'b0;
                        r_state          <= S_DONE;
                        r_valid[r_owner] <= 1'b1;
                        // Stores report zero read data.
                        r_rdata[r_owner] <= r_we ? '0 : mem_rdata;
                    end else if (w_tmo_hit) begin
                        r_mem_req        <= 1'b0;
                        r_state          <= S_DONE;
                        r_valid[r_owner] <= 1'b1;
                        r_err[r_owner]   <= 1'b1;
                    end else if (r_state == S_ISSUE) begin
                        r_state <= S_WAIT;
                    end
                end

                // Valid is visible during DONE; arbitration resumes in the
                // following IDLE cycle, after the requester has seen valid.
                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign f_valid = r_valid[OWN_F];
    assign f_err   = r_err[OWN_F];
    assign f_rdata = r_rdata[OWN_F];
    assign m_valid = r_valid[OWN_M];
    assign m_err   = r_err[OWN_M];
    assign m_rdata = r_rdata[OWN_M];

    assign f_stall = f_req & ~f_valid;
    assign m_stall = m_req & ~m_valid;

    // Memory-side fields are only presented while the request is up.
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_req & r_we;
    assign mem_addr  = r_mem_req ? r_addr  : '0;
    assign mem_wdata = r_mem_req ? r_wdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic [DATA_W-1:0] f_rdata;
    logic              f_valid, f_err, f_stall;
    logic              m_req = 1'b0;
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rdata;
    logic              m_valid, m_err, m_stall;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(1024),
        .STARVE_MAX(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata),
        .f_valid(f_valid), .f_err(f_err), .f_stall(f_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_valid(m_valid), .m_err(m_err), .m_stall(m_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Memory responder: acks ack_delay cycles after mem_req rises.
    logic [63:0] mem_model [0:127];
    int  ack_delay     = 1;
    bit  ack_en        = 1'b1;
    bit  force_ack     = 1'b0;
    int  req_age       = 0;
    int  mem_req_rises = 0;
    bit  mem_req_q     = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (mem_req && !mem_req_q) mem_req_rises++;
        mem_req_q = mem_req;
        mem_ack   = force_ack;
        mem_rdata = '0;
        if (rst || !mem_req) begin
            req_age = 0;
        end else if (ack_en) begin
            req_age++;
            if (req_age == ack_delay + 1) begin
                mem_ack = 1'b1;
                if (mem_we) mem_model[mem_addr[9:3]] = mem_wdata;
                else        mem_rdata = mem_model[mem_addr[9:3]];
                req_age = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({f_valid, f_err, m_valid, m_err, mem_req, mem_we, f_stall, m_stall} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {f_valid, f_err, m_valid, m_err, mem_req, mem_we, f_stall, m_stall});
        end
        checks++;
        if ({f_rdata, m_rdata, mem_addr, mem_wdata} !== 256'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {f_rdata, m_rdata, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        tick(1);
        $display("txn reset done");
    endtask

    task automatic test_m_load();
        mem_model[8] = 64'hDEAD;
        ack_delay = 1;
        m_we = 1'b0; m_addr = 64'h40; m_req = 1'b1;
        tick(1);
        checks++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 64'h40) begin
            failures++;
            $display("FAIL m_load_issue: got req/we=%b addr=%h expected 10 addr=40", {mem_req, mem_we}, mem_addr);
        end
        tick(1);
        checks++;
        if ({m_valid, m_stall} !== 2'b01) begin
            failures++;
            $display("FAIL m_load_early: got valid/stall=%b expected 01", {m_valid, m_stall});
        end
        tick(1);
        checks++;
        if ({m_valid, m_err, mem_req} !== 3'b100 || m_rdata !== 64'hDEAD) begin
            failures++;
            $display("FAIL m_load_resp: got v/e/req=%b rdata=%h expected 100 rdata=dead", {m_valid, m_err, mem_req}, m_rdata);
        end
        $display("txn M load addr=40 rdata=%h", m_rdata);
        m_req = 1'b0;
        tick(1);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL m_load_pulse: got valid=%b expected 0", m_valid);
        end
        tick(1);
    endtask

    task automatic test_ack_in_issue();
        mem_model[9] = 64'h1234_5678;
        ack_delay = 0;
        m_we = 1'b0; m_addr = 64'h48; m_req = 1'b1;
        tick(1);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL issue_ack_early: got valid=%b expected 0", m_valid);
        end
        tick(1);
        checks++;
        if (m_valid !== 1'b1 || m_rdata !== 64'h1234_5678) begin
            failures++;
            $display("FAIL issue_ack_resp: got valid=%b rdata=%h expected 1 rdata=12345678", m_valid, m_rdata);
        end
        $display("txn M load addr=48 (ack in ISSUE) rdata=%h", m_rdata);
        m_req = 1'b0;
        ack_delay = 1;
        tick(2);
    endtask

    task automatic test_f_and_m();
        mem_model[2] = 64'hF0F0_0001;
        mem_model[3] = 64'h0303_0303;
        f_addr = 64'h10; f_req = 1'b1;
        m_we = 1'b0; m_addr = 64'h18; m_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            checks++;
            if ({f_stall, f_valid} !== 2'b10) begin
                failures++;
                $display("FAIL fm_f_stall c=%0d: got stall/valid=%b expected 10", c, {f_stall, f_valid});
            end
        end
        checks++;
        if (m_valid !== 1'b1 || m_rdata !== 64'h0303_0303) begin
            failures++;
            $display("FAIL fm_m_first: got valid=%b rdata=%h expected 1 rdata=03030303", m_valid, m_rdata);
        end
        $display("txn M load addr=18 rdata=%h (F waiting)", m_rdata);
        m_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            checks++;
            if ({f_stall, f_valid} !== 2'b10) begin
                failures++;
                $display("FAIL fm_f_wait c=%0d: got stall/valid=%b expected 10", c, {f_stall, f_valid});
            end
        end
        tick(1);
        checks++;
        if ({f_valid, f_err, f_stall} !== 3'b100 || f_rdata !== 64'hF0F0_0001) begin
            failures++;
            $display("FAIL fm_f_second: got v/e/stall=%b rdata=%h expected 100 rdata=f0f00001", {f_valid, f_err, f_stall}, f_rdata);
        end
        $display("txn F read addr=10 rdata=%h", f_rdata);
        f_req = 1'b0;
        tick(2);
    endtask

    task automatic test_starvation();
        // 1 = M grant, 0 = F grant, in completion order (bit 0 first).
        logic [9:0] exp_order;
        int seen;
        int cyc;
        exp_order = 10'b0111101111;
        seen = 0;
        cyc  = 0;
        f_addr = 64'h10; f_req = 1'b1;
        m_we = 1'b0; m_addr = 64'h18; m_req = 1'b1;
        while (seen < 10 && cyc < 120) begin
            tick(1);
            cyc++;
            if (f_valid || m_valid) begin
                checks++;
                if ({f_valid, m_valid} !== {~exp_order[seen], exp_order[seen]}) begin
                    failures++;
                    $display("FAIL starve_grant%0d: got f/m=%b expected %b", seen,
                             {f_valid, m_valid}, {~exp_order[seen], exp_order[seen]});
                end
                $display("txn starve grant %0d to %s", seen, m_valid ? "M" : "F");
                seen++;
            end
        end
        checks++;
        if (seen != 10) begin
            failures++;
            $display("FAIL starve_timeout: got %0d grants expected 10", seen);
        end
        f_req = 1'b0;
        m_req = 1'b0;
        tick(6);
    endtask

    task automatic test_adr();
        int rises0;
        rises0 = mem_req_rises;
        m_we = 1'b1; m_addr = 64'd1020; m_wdata = 64'hAA; m_req = 1'b1;
        tick(1);
        checks++;
        if ({m_valid, m_err, mem_req} !== 3'b110 || m_rdata !== 64'h0) begin
            failures++;
            $display("FAIL adr_1020: got v/e/req=%b rdata=%h expected 110 rdata=0", {m_valid, m_err, mem_req}, m_rdata);
        end
        $display("txn M store addr=1020 err=%b", m_err);
        m_req = 1'b0;
        tick(1);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL adr_pulse: got valid=%b expected 0", m_valid);
        end
        tick(2);
        checks++;
        if (mem_req_rises != rises0) begin
            failures++;
            $display("FAIL adr_no_mem_req: got rises=%0d expected %0d", mem_req_rises, rises0);
        end
        m_we = 1'b1; m_addr = 64'd1016; m_wdata = 64'hCAFE_F00D_1234_5678; m_req = 1'b1;
        tick(1);
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 64'd1016 || mem_wdata !== 64'hCAFE_F00D_1234_5678) begin
            failures++;
            $display("FAIL st1016_issue: got req/we=%b addr=%h wdata=%h expected 11 3f8 cafef00d12345678",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick(2);
        checks++;
        if ({m_valid, m_err} !== 2'b10 || m_rdata !== 64'h0) begin
            failures++;
            $display("FAIL st1016_resp: got v/e=%b rdata=%h expected 10 rdata=0", {m_valid, m_err}, m_rdata);
        end
        $display("txn M store addr=1016 err=%b", m_err);
        m_req = 1'b0; m_we = 1'b0;
        tick(2);
        checks++;
        if (mem_model[127] !== 64'hCAFE_F00D_1234_5678) begin
            failures++;
            $display("FAIL st1016_mem: got %h expected cafef00d12345678", mem_model[127]);
        end
        f_addr = 64'd1016; f_req = 1'b1;
        tick(3);
        checks++;
        if ({f_valid, f_err} !== 2'b10 || f_rdata !== 64'hCAFE_F00D_1234_5678) begin
            failures++;
            $display("FAIL f1016_read: got v/e=%b rdata=%h expected 10 cafef00d12345678", {f_valid, f_err}, f_rdata);
        end
        $display("txn F read addr=1016 rdata=%h", f_rdata);
        f_req = 1'b0;
        tick(2);
        f_addr = 64'hFFFF_FFFF_FFFF_FFF8; f_req = 1'b1;
        tick(1);
        checks++;
        if ({f_valid, f_err} !== 2'b11 || f_rdata !== 64'h0) begin
            failures++;
            $display("FAIL f_adr_high: got v/e=%b rdata=%h expected 11 rdata=0", {f_valid, f_err}, f_rdata);
        end
        $display("txn F read addr=fffffffffffffff8 err=%b", f_err);
        f_req = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid_access();
        int bad;
        bad = 0;
        ack_en = 1'b0;
        m_we = 1'b0; m_addr = 64'h40; m_req = 1'b1;
        tick(3);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_wait: got mem_req=%b expected 1", mem_req);
        end
        rst = 1'b1; force_ack = 1'b1; m_req = 1'b0;
        tick(1);
        checks++;
        if ({mem_req, m_valid, m_err, f_valid} !== 4'b0000 || mem_addr !== 64'h0 || m_rdata !== 64'h0) begin
            failures++;
            $display("FAIL rstmid_clear: got req/v/e/fv=%b addr=%h rdata=%h expected 0000 0 0",
                     {mem_req, m_valid, m_err, f_valid}, mem_addr, m_rdata);
        end
        rst = 1'b0; force_ack = 1'b0;
        tick(1);
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (m_valid || f_valid || mem_req) bad++;
            tick(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_late_ack: got %0d active cycles expected 0", bad);
        end
        $display("txn reset mid-access discarded");
        ack_en = 1'b1;
    endtask

    task automatic test_no_ack();
        ack_en = 1'b0;
        m_we = 1'b0; m_addr = 64'h20; m_req = 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
        tick(16);
        checks++;
        if (m_valid !== 1'b0 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL tmo_early: got valid=%b req=%b expected 0 1", m_valid, mem_req);
        end
        tick(1);
        checks++;
        if ({m_valid, m_err, mem_req} !== 3'b110 || m_rdata !== 64'h0) begin
            failures++;
            $display("FAIL tmo_fire: got v/e/req=%b rdata=%h expected 110 rdata=0", {m_valid, m_err, mem_req}, m_rdata);
        end
        $display("txn M load addr=20 timed out err=%b", m_err);
        m_req = 1'b0;
        tick(2);
`else
        begin
            int vcnt;
            vcnt = 0;
            for (int c = 0; c < 40; c++) begin
                tick(1);
                if (m_valid) vcnt++;
            end
            checks++;
            if (vcnt != 0 || m_stall !== 1'b1 || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL noack_hold: got valids=%0d stall=%b req=%b expected 0 1 1", vcnt, m_stall, mem_req);
            end
            $display("txn M load addr=20 stalled without ack");
        end
        m_req = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
`endif
        ack_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = 64'h0;
        test_reset();
        test_m_load();
        test_ack_in_issue();
        test_f_and_m();
        test_starvation();
        test_adr();
        test_reset_mid_access();
        test_no_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
